// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle DECODE/EXEC/WB control sequencer
// Optional retire counter enabled by defining MCU_RETIRE_CNT_EN.
module multicycle_control_unit #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int IMM_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               hold,
  input  logic               alu_zero,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  rs,
  output logic [REG_AW-1:0]  rt,
  output logic [IMM_W-1:0]   imm,
  output logic [2:0]         alu_op,
  output logic               select_imm,
  output logic               reg_write,
  output logic               pc_en,
  output logic               branch_taken,
  output logic               busy
`ifdef MCU_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]   retire_cnt
`endif
);

  generate
    if (INSTR_W < 4 + 3*REG_AW || IMM_W > INSTR_W - 4 - 2*REG_AW || CNT_W < 1) begin : g_illegal
      $error("multicycle_control_unit: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t             state, state_nx;
  logic [INSTR_W-1:0] instr_q;
  logic [3:0]         op;
  logic [2:0]         dec_alu_op;
  logic               dec_sel, dec_writes, dec_branch;
  logic               writes_q, is_branch_q, branch_q;
  logic               accept, wb_go;

  assign instr_ready = rst_n & ~hold & (state == S_IDLE || state == S_WB);
  assign accept      = instr_valid & instr_ready;
  // Strobes fire only in a WB cycle that is not stalled, so a held WB never repeats them.
  assign wb_go       = rst_n & ~hold & (state == S_WB);

  assign op  = instr_q[INSTR_W-1 -: 4];
  assign rd  = instr_q[INSTR_W-5 -: REG_AW];
  assign rs  = instr_q[INSTR_W-5-REG_AW -: REG_AW];
  assign rt  = instr_q[INSTR_W-5-2*REG_AW -: REG_AW];
  assign imm = instr_q[IMM_W-1:0];

  assign reg_write    = wb_go & writes_q;
  assign pc_en        = wb_go;
  assign branch_taken = wb_go & branch_q;
  assign busy         = (state != S_IDLE);

  always_comb begin
    dec_alu_op = op[2:0];
    dec_sel    = op[3];
    dec_writes = 1'b1;
    dec_branch = 1'b0;
    if (op == 4'b1111) begin
      dec_alu_op = 3'b000;
    end else if (op == 4'b1110) begin
      dec_alu_op = 3'b001;
      dec_writes = 1'b0;
      dec_branch = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (!hold) begin
      case (state)
        S_IDLE:   if (accept) state_nx = S_DECODE;
        S_DECODE: state_nx = S_EXEC;
        S_EXEC:   state_nx = S_WB;
        S_WB:     state_nx = accept ? S_DECODE : S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      alu_op      <= 3'b000;
      select_imm  <= 1'b0;
      writes_q    <= 1'b0;
      is_branch_q <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) instr_q <= instr;
      if (state == S_DECODE && !hold) begin
        alu_op      <= dec_alu_op;
        select_imm  <= dec_sel;
        writes_q    <= dec_writes;
        is_branch_q <= dec_branch;
      end
      if (state == S_EXEC && !hold) branch_q <= is_branch_q & alu_zero;
    end
  end

`ifdef MCU_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) retire_cnt <= '0;
    else if (wb_go) retire_cnt <= retire_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
// Retire counter checks are active when MCU_RETIRE_CNT_EN is defined.
module tb_multicycle_control_unit;
  logic        clk = 1'b0;
  logic        rst_n, instr_valid, hold, alu_zero;
  logic [15:0] instr;
  logic        instr_ready, select_imm, reg_write, pc_en, branch_taken, busy;
  logic [2:0]  rd, rs, rt, alu_op;
  logic [5:0]  imm;
`ifdef MCU_RETIRE_CNT_EN
  logic [3:0]  retire_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rw_pulses = 0;
  int exp_pulses = 0;
  int model_cnt = 0;

  multicycle_control_unit #(.INSTR_W(16), .REG_AW(3), .IMM_W(6), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .hold(hold), .alu_zero(alu_zero),
    .rd(rd), .rs(rs), .rt(rt), .imm(imm), .alu_op(alu_op), .select_imm(select_imm),
    .reg_write(reg_write), .pc_en(pc_en), .branch_taken(branch_taken), .busy(busy)
`ifdef MCU_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Regfile's view: a write happens at every edge where reg_write is high.
  always @(posedge clk) if (reg_write === 1'b1) rw_pulses <= rw_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-class table.
  function automatic void model(input logic [15:0] ins, output logic [2:0] aop,
                                output logic sel, output logic wr, output logic br);
    int opc;
    opc = int'(ins >> 12);
    br  = (opc == 14);
    wr  = !br;
    sel = (opc >= 8);
    aop = br ? 3'd1 : (opc == 15 ? 3'd0 : 3'(opc % 8));
  endfunction

  task automatic run_instr(input logic [15:0] ins, input logic az);
    logic [2:0] aop;
    logic sel, wr, br;
    model(ins, aop, sel, wr, br);
    instr = ins; instr_valid = 1'b1;
    #1 check("ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    check("busy_decode", busy, 1);
    check("no_pc_decode", pc_en, 0);
    @(posedge clk); #1;
    alu_zero = az;
    check("alu_op", alu_op, aop);
    check("select_imm", select_imm, sel);
    check("no_wr_exec", reg_write, 0);
    @(posedge clk); #1;
    check("wb_reg_write", reg_write, wr);
    check("wb_pc_en", pc_en, 1);
    check("wb_branch", branch_taken, br & az);
    check("rd", rd, (ins >> 9) % 8);
    check("rs", rs, (ins >> 6) % 8);
    check("rt", rt, (ins >> 3) % 8);
    check("imm", imm, ins % 64);
    if (wr) exp_pulses++;
    model_cnt++;
    @(posedge clk); #1;
    check("idle_after_wb", busy, 0);
    check("idle_no_pc", pc_en, 0);
    check("idle_keeps_alu_op", alu_op, aop);
  endtask

  initial begin
    logic [15:0] bb [2];
    int acc [2];
    int idx, np, p0;
    logic hs;
    logic [2:0] got_rd [2];
    logic [5:0] got_imm [2];
    logic [2:0] got_aop [2];

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; hold = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("ready_in_reset", instr_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_branch", branch_taken, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_select_imm", select_imm, 0);
    check("rst_rd", rd, 0);
    check("rst_imm", imm, 0);
`ifdef MCU_RETIRE_CNT_EN
    check("rst_retire_cnt", retire_cnt, 0);
`endif

    run_instr(16'h0298, 1'b0);
    run_instr(16'hE000, 1'b1);
    run_instr(16'hE000, 1'b0);

    // Back-to-back ADDI/SUBI with valid held high
    bb[0] = 16'h8A85; bb[1] = 16'h9C01;
    idx = 0; np = 0; acc[0] = -1; acc[1] = -1;
    instr = bb[0]; instr_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      hs = instr_valid & instr_ready;
      if (reg_write === 1'b1 && np < 2) begin
        got_rd[np] = rd; got_imm[np] = imm; got_aop[np] = alu_op; np++;
      end
      @(posedge clk); #1;
      if (hs && idx < 2) begin
        acc[idx] = cyc; idx++;
        if (idx < 2) instr = bb[idx]; else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    check("b2b_accepts", idx, 2);
    check("b2b_spacing", acc[1] - acc[0], 3);
    check("b2b_pulses", np, 2);
    check("b2b_rd0", got_rd[0], 5);
    check("b2b_rd1", got_rd[1], 6);
    check("b2b_imm0", got_imm[0], 5);
    check("b2b_imm1", got_imm[1], 1);
    check("b2b_aop0", got_aop[0], 0);
    check("b2b_aop1", got_aop[1], 1);
    exp_pulses += 2; model_cnt += 2;

    // Hold for 4 cycles entering WB
    instr = 16'h0298; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold = 1'b1;
    p0 = rw_pulses;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_no_wr", reg_write, 0);
      check("hold_no_pc", pc_en, 0);
      check("hold_not_ready", instr_ready, 0);
      check("hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    #1;
    check("hold_release_wr", reg_write, 1);
    check("hold_release_pc", pc_en, 1);
    @(posedge clk); #1;
    check("hold_idle", busy, 0);
    check("hold_single_pulse", rw_pulses - p0, 1);
    exp_pulses++; model_cnt++;

    // Reset during EXEC aborts the instruction
    instr = 16'h0298; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1;
    p0 = rw_pulses;
    rst_n = 1'b0;
    #1 check("abort_ready_low", instr_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", instr_ready, 1);
    check("abort_no_wr", reg_write, 0);
    check("abort_no_pc", pc_en, 0);
    check("abort_alu_op", alu_op, 0);
    repeat (3) @(posedge clk);
    #1 check("abort_no_pulse", rw_pulses - p0, 0);
    model_cnt = 0;

    for (int i = 0; i < 17; i++) run_instr(16'($urandom), 1'($urandom_range(0, 1)));
`ifdef MCU_RETIRE_CNT_EN
    check("retire_wrap", retire_cnt, model_cnt % 16);
`endif
    for (int i = 0; i < 6; i++) run_instr(16'($urandom), 1'($urandom_range(0, 1)));
`ifdef MCU_RETIRE_CNT_EN
    check("retire_final", retire_cnt, model_cnt % 16);
`endif
    check("total_pulses", rw_pulses, exp_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
